dmem_arbiter: RTL

//  Shares one single-port data-memory bus between two requesters:
//  - CPU M-stage load/store port (cpu_*).
//  - DMA/debug port (dma_*).

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/store_lane_gen.sv | 39 +++
 rtl/dmem_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory arbiter.
//   - load/store size codes
//   - FSM state encoding
//   - grant (port id) encoding
//   - misalignment helper (used only when ALIGN_CHECK_EN is defined)
package dmem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DMA = 1'b1
  } gnt_e;

  // Half needs addr[0]=0; word needs addr[1:0]=0; reserved size always faults.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_WORD: bad = (addr_lo != 2'b00);
      SZ_HALF: bad = addr_lo[0];
      SZ_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_lane_gen.sv
// store_lane_gen: combinational store byte-lane steering.
// Ports:
//   size_i     access size code (reserved code treated as word)
//   addr_lo_i  byte address bits [1:0]
//   wdata_i    right-aligned store data
//   be_o       byte enables for the addressed lanes
//   wdata_o    store data moved onto its lanes, unused lanes zero
module store_lane_gen
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o
);

  always_comb begin
    be_o    = '1;
    wdata_o = wdata_i;
    case (size_i)
      SZ_HALF: begin
        if (addr_lo_i[1]) begin
          be_o    = 4'b1100;
          wdata_o = {wdata_i[15:0], 16'h0000};
        end else begin
          be_o    = 4'b0011;
          wdata_o = {16'h0000, wdata_i[15:0]};
        end
      end
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {24'h000000, wdata_i[7:0]} << {addr_lo_i, 3'b000};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data-memory bus between the CPU
// M-stage port (cpu_*) and a DMA/debug port (dma_*). Each access goes
// IDLE -> ISSUE (mem_en held until mem_ready) -> RESP (one-cycle ack).
// Parameters:
//   ADDR_W      byte-address width; mem_addr carries addr[ADDR_W-1:2]
//   FIXED_PRIO  0 = round-robin on contention, 1 = CPU always wins
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   cpu_/dma_ req,we,size,sext,addr,wdata   requester inputs (held until ack)
//   cpu_/dma_ ack,rdata,err     completion pulse, load result, misalign flag
//   mem_en,we,addr,be,wdata     registered memory request
//   mem_rdata, mem_ready        memory read word and completion
// Build option:
//   ALIGN_CHECK_EN  when defined, misaligned accesses skip the memory and
//                   complete with err=1, rdata=0; otherwise err is tied 0.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_sext,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_err,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [1:0]        dma_size,
  input  logic              dma_sext,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_ack,
  output logic [31:0]       dma_rdata,
  output logic              dma_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  state_e state_q, state_d;
  gnt_e   gnt_q, gnt_d, last_q;

  logic [1:0]        size_q;
  logic              sext_q;
  logic [1:0]        addr_lo_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic              mem_we_q;
  logic [ADDR_W-3:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q;

  logic              any_req;
  logic              sel_we;
  logic [1:0]        sel_size;
  logic              sel_sext;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_err;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic [31:0]       load_data;
  logic              resp_cpu, resp_dma;

  assign any_req = cpu_req | dma_req;

  // Arbitration; the result is only consumed in IDLE.
  always_comb begin
    gnt_d = GNT_CPU;
    if (cpu_req && dma_req) begin
      gnt_d = (FIXED_PRIO || (last_q == GNT_DMA)) ? GNT_CPU : GNT_DMA;
    end else if (dma_req) begin
      gnt_d = GNT_DMA;
    end
  end

  always_comb begin
    if (gnt_d == GNT_DMA) begin
      sel_we    = dma_we;
      sel_size  = dma_size;
      sel_sext  = dma_sext;
      sel_addr  = dma_addr;
      sel_wdata = dma_wdata;
    end else begin
      sel_we    = cpu_we;
      sel_size  = cpu_size;
      sel_sext  = cpu_sext;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
    end
  end

`ifdef ALIGN_CHECK_EN
  assign sel_err = misaligned(sel_size, sel_addr[1:0]);
`else
  assign sel_err = 1'b0;
`endif

  store_lane_gen u_lane (
    .size_i    (sel_size),
    .addr_lo_i (sel_addr[1:0]),
    .wdata_i   (sel_wdata),
    .be_o      (lane_be),
    .wdata_o   (lane_wdata)
  );

  // Load extraction on the live memory word, using the latched access shape.
  always_comb begin
    logic [15:0] half;
    logic [7:0]  byte_v;
    half      = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    byte_v    = 8'(mem_rdata >> {addr_lo_q, 3'b000});
    load_data = mem_rdata;
    case (size_q)
      SZ_HALF: load_data = {{16{sext_q & half[15]}}, half};
      SZ_BYTE: load_data = {{24{sext_q & byte_v[7]}}, byte_v};
      default: ;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_req)   state_d = sel_err ? ST_RESP : ST_ISSUE;
      ST_ISSUE: if (mem_ready) state_d = ST_RESP;
      ST_RESP:                 state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Access datapath: fields latched at grant, read data captured on mem_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q       <= GNT_CPU;
      last_q      <= GNT_DMA;
      size_q      <= '0;
      sext_q      <= 1'b0;
      addr_lo_q   <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      if (state_q == ST_IDLE && any_req) begin
        gnt_q       <= gnt_d;
        last_q      <= gnt_d;
        size_q      <= sel_size;
        sext_q      <= sel_sext;
        addr_lo_q   <= sel_addr[1:0];
        err_q       <= sel_err;
        rdata_q     <= '0;
        mem_we_q    <= sel_we;
        mem_addr_q  <= sel_addr[ADDR_W-1:2];
        mem_be_q    <= sel_we ? lane_be : '1;
        mem_wdata_q <= sel_we ? lane_wdata : '0;
      end
      if (state_q == ST_ISSUE && mem_ready) begin
        rdata_q <= load_data;
      end
    end
  end

  // FSM: outputs
  always_comb begin
    resp_cpu  = (state_q == ST_RESP) && (gnt_q == GNT_CPU);
    resp_dma  = (state_q == ST_RESP) && (gnt_q == GNT_DMA);
    mem_en    = (state_q == ST_ISSUE);
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_be    = mem_be_q;
    mem_wdata = mem_wdata_q;
    cpu_ack   = resp_cpu;
    dma_ack   = resp_dma;
    cpu_err   = resp_cpu & err_q;
    dma_err   = resp_dma & err_q;
    cpu_rdata = resp_cpu ? rdata_q : '0;
    dma_rdata = resp_dma ? rdata_q : '0;
  end

endmodule
